// File: rtl/mem_stage_pipe.sv
// rtl/mem_stage_pipe.sv - MEM stage with req/ack data bus, upstream stall, timeout and MEM/WB register
module mem_stage_pipe #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              init,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_res,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [DATA_W-1:0] ex_pc1,
    input  logic [REG_W-1:0]  ex_wreg,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_write_pc_4,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              bus_err
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               mem_op;
    logic               ack_hit;
    logic               to_hit;
    logic               stall_c;
    logic               accept;
    logic               retire;

    // Fields of the accepted memory instruction that are only needed at retire time
    logic               h_reg_write;
    logic [REG_W-1:0]   h_wreg;
    logic [DATA_W-1:0]  h_alu_res;
    logic [DATA_W-1:0]  h_pc1;
    logic               h_mem_to_reg;
    logic               h_write_pc_4;

    assign mem_op  = ex_valid & (ex_mem_read | ex_mem_write);
    assign ack_hit = (state == BUSY) & bus_ack;

    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign to_hit = (state == BUSY) & ~bus_ack & (cnt == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign to_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_c   = 1'b0;
        accept    = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall_c   = 1'b1;
                    accept    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (ack_hit || to_hit) begin
                    retire    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (TIMEOUT > 0) cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Held low during reset so every output reads 0 while init is asserted
    assign stall = stall_c & init;

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            h_reg_write  <= 1'b0;
            h_wreg       <= '0;
            h_alu_res    <= '0;
            h_pc1        <= '0;
            h_mem_to_reg <= 1'b0;
            h_write_pc_4 <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_wreg      <= '0;
            wb_wdata     <= '0;
            bus_err      <= 1'b0;
        end else begin
            bus_req <= (state_nxt == BUSY);
            if (accept) begin
                bus_we       <= ex_mem_write;
                bus_addr     <= ex_alu_res[ADDR_W-1:0];
                bus_wdata    <= ex_store_data;
                h_reg_write  <= ex_reg_write;
                h_wreg       <= ex_wreg;
                h_alu_res    <= ex_alu_res;
                h_pc1        <= ex_pc1;
                h_mem_to_reg <= ex_mem_to_reg;
                h_write_pc_4 <= ex_write_pc_4;
            end
            if (retire) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= ack_hit & h_reg_write;
                wb_wreg      <= h_wreg;
                wb_wdata     <= h_write_pc_4 ? h_pc1 : (h_mem_to_reg ? bus_rdata : h_alu_res);
            end else if ((state == IDLE) && ex_valid && !mem_op) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= ex_reg_write;
                wb_wreg      <= ex_wreg;
                wb_wdata     <= ex_write_pc_4 ? ex_pc1 : ex_alu_res;
            end else begin
                wb_valid     <= 1'b0;
                wb_reg_write <= 1'b0;
            end
            if (to_hit) bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb/tb_mem_stage_pipe.sv - directed and randomized bench for mem_stage_pipe against a memory/retire model
module tb_mem_stage_pipe;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        init;
    logic        ex_valid;
    logic [31:0] ex_alu_res, ex_store_data, ex_pc1;
    logic [4:0]  ex_wreg;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_write_pc_4;
    logic        stall, bus_req, bus_we;
    logic [9:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_wreg;
    logic [31:0] wb_wdata;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [1024];
    logic        exp_v, exp_rw, exp_dchk, exp_err;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;

    mem_stage_pipe #(.DATA_W(32), .ADDR_W(10), .REG_W(5), .TIMEOUT(TMO)) dut (
        .clk(clk), .init(init), .ex_valid(ex_valid), .ex_alu_res(ex_alu_res),
        .ex_store_data(ex_store_data), .ex_pc1(ex_pc1), .ex_wreg(ex_wreg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_write_pc_4(ex_write_pc_4), .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb();
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, exp_v});
        chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, exp_rw});
        if (exp_rw) chk("wb_wreg", {27'd0, wb_wreg}, {27'd0, exp_reg});
        if (exp_v && exp_dchk) chk("wb_wdata", wb_wdata, exp_data);
        chk("bus_err", {31'd0, bus_err}, {31'd0, exp_err});
    endtask

    task automatic do_alu(input logic [31:0] alu, input logic [31:0] pc1, input logic [4:0] wreg,
                          input logic rw, input logic wpc4, input logic valid, input logic stray);
        ex_valid = valid; ex_alu_res = alu; ex_pc1 = pc1; ex_wreg = wreg; ex_reg_write = rw;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_to_reg = 1'b0; ex_write_pc_4 = wpc4;
        ex_store_data = $urandom; bus_ack = stray; bus_rdata = $urandom;
        @(negedge clk);
        check_wb();
        chk("alu_stall", {31'd0, stall}, 32'd0);
        chk("alu_bus_req", {31'd0, bus_req}, 32'd0);
        tick();
        exp_v = valid; exp_rw = valid & rw; exp_reg = wreg;
        exp_data = wpc4 ? pc1 : alu; exp_dchk = 1'b1;
    endtask

    // ack_at: BUSY cycle (1-based) that carries bus_ack; 0 means no ack, so the access times out
    task automatic do_mem(input logic we, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] wreg, input int ack_at, input logic stray);
        logic [9:0]  a;
        logic [31:0] ld;
        logic        ack, tmo, done;
        a = addr[9:0];
        ld = 32'd0;
        done = 1'b0;
        ex_valid = 1'b1; ex_alu_res = addr; ex_store_data = sdata; ex_wreg = wreg;
        ex_reg_write = ~we; ex_mem_read = ~we; ex_mem_write = we; ex_mem_to_reg = ~we;
        ex_write_pc_4 = 1'b0; ex_pc1 = $urandom; bus_ack = stray; bus_rdata = $urandom;
        @(negedge clk);
        check_wb();
        chk("mem_idle_stall", {31'd0, stall}, 32'd1);
        chk("mem_idle_req", {31'd0, bus_req}, 32'd0);
        tick();
        exp_v = 1'b0; exp_rw = 1'b0;
        for (int c = 1; c <= TMO && !done; c++) begin
            ack = (c == ack_at);
            tmo = (ack_at == 0) && (c == TMO);
            bus_ack = ack;
            bus_rdata = (ack && !we) ? mem[a] : $urandom;
            @(negedge clk);
            check_wb();
            chk("busy_req", {31'd0, bus_req}, 32'd1);
            chk("busy_addr", {22'd0, bus_addr}, {22'd0, a});
            chk("busy_we", {31'd0, bus_we}, {31'd0, we});
            if (we) chk("busy_wdata", bus_wdata, sdata);
            chk("busy_stall", {31'd0, stall}, {31'd0, !(ack || tmo)});
            if (ack || tmo) begin
                ld = mem[a];
                if (ack && we) mem[a] = sdata;
                done = 1'b1;
            end
            tick();
            bus_ack = 1'b0;
            if (done) begin
                exp_v = 1'b1; exp_rw = ack & ~we; exp_reg = wreg;
                exp_data = ld; exp_dchk = ack & ~we;
                if (tmo) exp_err = 1'b1;
            end else begin
                exp_v = 1'b0; exp_rw = 1'b0;
            end
        end
    endtask

    initial begin
        int r;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[16] = 32'hDEADBEEF;
        init = 1'b0; ex_valid = 1'b0; ex_alu_res = '0; ex_store_data = '0; ex_pc1 = '0;
        ex_wreg = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_mem_to_reg = 1'b0; ex_write_pc_4 = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        exp_v = 1'b0; exp_rw = 1'b0; exp_dchk = 1'b0; exp_err = 1'b0; exp_reg = '0; exp_data = '0;
        tick();
        tick();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        init = 1'b1;

        do_alu(32'h2A, 32'h100, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        do_mem(1'b0, 32'h10, 32'h0, 5'd3, 4, 1'b0);
        do_mem(1'b1, 32'h3FF, 32'h55, 5'd0, 1, 1'b0);
        do_alu(32'h1234, 32'h200, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        do_mem(1'b0, 32'h20, 32'h0, 5'd9, 0, 1'b0);
        do_alu(32'h77, 32'h300, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
        do_mem(1'b0, 32'hFFFF_F3FF, 32'h0, 5'd4, 2, 1'b0);
        do_mem(1'b0, 32'h10, 32'h0, 5'd5, 1, 1'b1);
        do_alu(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 5);
            case (r)
                0, 1: do_alu($urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'b1,
                             1'($urandom));
                2: do_alu($urandom, $urandom, 5'($urandom), 1'b1, 1'b0, 1'b0, 1'($urandom));
                3: do_mem(1'b0, $urandom, $urandom, 5'($urandom), $urandom_range(1, TMO),
                          1'($urandom));
                4: do_mem(1'b1, $urandom, $urandom, 5'($urandom), $urandom_range(1, TMO),
                          1'($urandom));
                default: do_mem(1'($urandom), $urandom, $urandom, 5'($urandom),
                                $urandom_range(0, TMO), 1'b0);
            endcase
        end

        do_mem(1'b0, 32'h20, 32'h0, 5'd1, 0, 1'b0);
        ex_valid = 1'b1; ex_alu_res = 32'h44; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        ex_mem_write = 1'b0; ex_mem_to_reg = 1'b1; ex_write_pc_4 = 1'b0; ex_wreg = 5'd2;
        @(negedge clk);
        check_wb();
        tick();
        @(negedge clk);
        chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
        #2;
        init = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, bus_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("mid_rst_wb_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("mid_rst_addr", {22'd0, bus_addr}, 32'd0);
        chk("mid_rst_we", {31'd0, bus_we}, 32'd0);
        chk("mid_rst_err", {31'd0, bus_err}, 32'd0);
        ex_valid = 1'b0;
        tick();
        tick();
        init = 1'b1;
        exp_v = 1'b0; exp_rw = 1'b0; exp_err = 1'b0;
        do_mem(1'b0, 32'h10, 32'h0, 5'd6, 3, 1'b0);
        do_alu(32'h99, 32'h400, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
        do_alu(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
